// File: rtl/coin_credit_ctrl_pkg.sv
// Shared coin values, FSM encoding and coin-vector helpers
// for the vending credit controller.
package coin_credit_ctrl_pkg;

    localparam int PENNY_VAL   = 1;
    localparam int NICKLE_VAL  = 5;
    localparam int DIME_VAL    = 10;
    localparam int QUARTER_VAL = 25;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        ACCUM  = 2'd1,
        VEND   = 2'd2,
        CHANGE = 2'd3
    } state_t;

    typedef struct packed {
        logic quarter;
        logic dime;
        logic nickle;
        logic penny;
    } coin_vec_t;

    function automatic int coin_count(input coin_vec_t c);
        return int'(c.quarter) + int'(c.dime)
             + int'(c.nickle) + int'(c.penny);
    endfunction

    // Total value of the flagged coins; meaningful when exactly one is set.
    function automatic int coin_value(input coin_vec_t c);
        return (c.quarter ? QUARTER_VAL : 0)
             + (c.dime    ? DIME_VAL    : 0)
             + (c.nickle  ? NICKLE_VAL  : 0)
             + (c.penny   ? PENNY_VAL   : 0);
    endfunction

endpackage

// File: rtl/coin_credit_ctrl_if.sv
// Sensor/keypad inputs and vend/change outputs of the
// credit controller, bundled as one interface.
interface coin_credit_ctrl_if #(
    parameter int CREDIT_W = 8
);
    logic                penny;
    logic                nickle;
    logic                dime;
    logic                quarter;
    logic                select;
    logic                cancel;
    logic [CREDIT_W-1:0] credit;
    logic                dispense;
    logic                short_funds;
    logic                coin_reject;
    logic                chg_quarter;
    logic                chg_dime;
    logic                chg_nickle;
    logic                chg_penny;
    logic                busy;

    modport master (
        output penny, nickle, dime, quarter,
        output select, cancel,
        input  credit, dispense, short_funds, coin_reject,
        input  chg_quarter, chg_dime, chg_nickle, chg_penny,
        input  busy
    );

    modport slave (
        input  penny, nickle, dime, quarter,
        input  select, cancel,
        output credit, dispense, short_funds, coin_reject,
        output chg_quarter, chg_dime, chg_nickle, chg_penny,
        output busy
    );
endinterface

// File: rtl/coin_change_maker.sv
// Greedy change selector: picks the largest coin not above
// the given credit and reports its value; nothing when credit is 0.
module coin_change_maker
    import coin_credit_ctrl_pkg::*;
#(
    parameter int CREDIT_W = 8
) (
    input  logic [CREDIT_W-1:0] credit,
    output coin_vec_t           coin,
    output logic [CREDIT_W-1:0] value
);

    always_comb begin
        coin  = '0;
        value = '0;
        priority case (1'b1)
            credit >= CREDIT_W'(QUARTER_VAL): begin
                coin.quarter = 1'b1;
                value        = CREDIT_W'(QUARTER_VAL);
            end
            credit >= CREDIT_W'(DIME_VAL): begin
                coin.dime = 1'b1;
                value     = CREDIT_W'(DIME_VAL);
            end
            credit >= CREDIT_W'(NICKLE_VAL): begin
                coin.nickle = 1'b1;
                value       = CREDIT_W'(NICKLE_VAL);
            end
            credit != '0: begin
                coin.penny = 1'b1;
                value      = CREDIT_W'(PENNY_VAL);
            end
            default: begin
                coin  = '0;
                value = '0;
            end
        endcase
    end

endmodule

// File: rtl/coin_credit_ctrl.sv
// Vending credit controller: coin edge detection, credit
// accumulation, single-item vend and greedy change payout.
module coin_credit_ctrl
    import coin_credit_ctrl_pkg::*;
#(
    parameter int PRICE      = 65,
    parameter int MAX_CREDIT = 200,
    parameter int CREDIT_W   = 8
) (
    input logic               clk,
    input logic               reset,
    coin_credit_ctrl_if.slave bus
);

    localparam int SW = CREDIT_W + 1;

    state_t              state;
    logic [CREDIT_W-1:0] credit_q;
    coin_vec_t           prev;
    coin_vec_t           lvl;
    coin_vec_t           ev;
    coin_vec_t           chg_sel;
    coin_vec_t           chg_q;
    logic [CREDIT_W-1:0] chg_val;
    logic [SW-1:0]       sum;
    logic [CREDIT_W-1:0] add;
    logic                coin_ok;
    logic                accept;
    logic                reject;
    logic                dispense_q;
    logic                short_q;
    logic                reject_q;
    logic                busy_q;

    assign lvl = {bus.quarter, bus.dime, bus.nickle, bus.penny};
    assign ev  = coin_vec_t'(lvl & ~prev);
    assign sum = {1'b0, credit_q} + SW'(coin_value(ev));

    // Coins are only taken while collecting and only one at a time.
    assign coin_ok = (state == IDLE) || (state == ACCUM);
    assign accept  = coin_ok && (coin_count(ev) == 1)
                  && (sum <= SW'(MAX_CREDIT));
    assign reject  = (|ev) && !accept;
    assign add     = accept ? sum[CREDIT_W-1:0] : credit_q;

    coin_change_maker #(
        .CREDIT_W (CREDIT_W)
    ) u_change (
        .credit (credit_q),
        .coin   (chg_sel),
        .value  (chg_val)
    );

    always_ff @(posedge clk) begin
        if (reset) begin
            state      <= IDLE;
            credit_q   <= '0;
            prev       <= '1;
            chg_q      <= '0;
            dispense_q <= 1'b0;
            short_q    <= 1'b0;
            reject_q   <= 1'b0;
            busy_q     <= 1'b0;
        end else begin
            prev       <= lvl;
            chg_q      <= '0;
            dispense_q <= 1'b0;
            short_q    <= 1'b0;
            reject_q   <= reject;
            unique case (state)
                IDLE: begin
                    busy_q <= 1'b0;
                    if (accept) begin
                        credit_q <= add;
                        state    <= ACCUM;
                    end
                end
                ACCUM: begin
                    credit_q <= add;
                    busy_q   <= 1'b0;
                    if (bus.cancel) begin
                        state  <= CHANGE;
                        busy_q <= 1'b1;
                    end else if (bus.select
                        && credit_q >= CREDIT_W'(PRICE)) begin
                        state  <= VEND;
                        busy_q <= 1'b1;
                    end else if (bus.select) begin
                        short_q <= 1'b1;
                    end
                end
                VEND: begin
                    dispense_q <= 1'b1;
                    credit_q   <= credit_q - CREDIT_W'(PRICE);
                    if (credit_q == CREDIT_W'(PRICE)) begin
                        state  <= IDLE;
                        busy_q <= 1'b0;
                    end else begin
                        state  <= CHANGE;
                        busy_q <= 1'b1;
                    end
                end
                CHANGE: begin
                    chg_q    <= chg_sel;
                    credit_q <= credit_q - chg_val;
                    if (credit_q == chg_val) begin
                        state  <= IDLE;
                        busy_q <= 1'b0;
                    end else begin
                        busy_q <= 1'b1;
                    end
                end
            endcase
        end
    end

    assign bus.credit      = credit_q;
    assign bus.dispense    = dispense_q;
    assign bus.short_funds = short_q;
    assign bus.coin_reject = reject_q;
    assign bus.chg_quarter = chg_q.quarter;
    assign bus.chg_dime    = chg_q.dime;
    assign bus.chg_nickle  = chg_q.nickle;
    assign bus.chg_penny   = chg_q.penny;
    assign bus.busy        = busy_q;

endmodule
